// File: rtl/lq_mem_responder_pkg.sv
// Shared definitions for the load-queue memory responder: bus command
// encodings, memory tag width, and the tag-table entry layout.
package lq_mem_responder_pkg;

  // Memory tags are 4 bits; tag 0 means "no tag", so 15 tags are usable.
  localparam int MEM_TAG_W = 4;
  localparam int NUM_TAGS  = (1 << MEM_TAG_W) - 1;

  // Width of the stored load-queue index. It is fixed here so that the
  // entry type can live in the package; it covers queues up to 256 entries.
  localparam int LQ_IDX_MAX_W = 8;

  typedef enum logic [1:0] {
    BUS_NONE = 2'd0,
    BUS_LOAD = 2'd1
  } bus_cmd_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } lq_mem_state_e;

  // valid: tag is owned by an in-flight load.
  // live : the load was not squashed and still wants its data.
  typedef struct packed {
    logic                    valid;
    logic                    live;
    logic [LQ_IDX_MAX_W-1:0] lq_idx;
  } lq_mem_tag_entry_t;

  // Request waiting to be issued (or retried) on the memory bus.
  typedef struct packed {
    logic [63:0]             addr;
    logic [LQ_IDX_MAX_W-1:0] lq_idx;
  } lq_mem_pending_t;

endpackage

// File: rtl/lq_mem_tag_table.sv
// Tag table for in-flight loads, indexed by memory tag 1..15.
// Ports:
//   clock, reset      clock and asynchronous active-low reset
//   wr_en/wr_tag/     issue-side write: record an accepted load
//   wr_entry
//   rd_tag            return-side tag (0 = no return this cycle)
//   rd_entry          current contents for rd_tag; cleared at the edge if valid
//   clear_live        squash: drop the live flag of every entry
//   outstanding       number of valid entries
module lq_mem_tag_table
  import lq_mem_responder_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [MEM_TAG_W-1:0] wr_tag,
  input  lq_mem_tag_entry_t    wr_entry,
  input  logic [MEM_TAG_W-1:0] rd_tag,
  output lq_mem_tag_entry_t    rd_entry,
  input  logic                 clear_live,
  output logic [CNT_W-1:0]     outstanding
);

  lq_mem_tag_entry_t tbl_q [1:NUM_TAGS];
  lq_mem_tag_entry_t tbl_d [1:NUM_TAGS];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_hit;

  always_comb begin
    rd_entry = '0;
    if (rd_tag != '0) rd_entry = tbl_q[rd_tag];
  end

  assign rd_hit      = rd_entry.valid;
  assign outstanding = cnt_q;

  // Order matters: squash, then return-clear, then issue-write, so a tag
  // that retires and is reassigned in the same cycle ends up with the new owner.
  always_comb begin
    tbl_d = tbl_q;
    if (clear_live) begin
      for (int t = 1; t <= NUM_TAGS; t++) tbl_d[t].live = 1'b0;
    end
    if (rd_hit) tbl_d[rd_tag] = '0;
    if (wr_en) tbl_d[wr_tag] = wr_entry;
    // A return for an unowned tag never decrements, so no underflow.
    cnt_d = cnt_q + CNT_W'(wr_en) - CNT_W'(rd_hit);
  end

  // NOTE: the table is held in flops, not RAM, so every entry is cleared by
  // the asynchronous reset; in-flight loads must be forgotten immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int t = 1; t <= NUM_TAGS; t++) tbl_q[t] <= '0;
      cnt_q <= '0;
    end else begin
      tbl_q <= tbl_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lq_mem_responder.sv
// Memory-side responder for the load queue. Accepts one load request per
// cycle, issues it on the processor-memory bus (retrying on rejection),
// tracks in-flight loads by memory tag and returns each load's data as a
// one-cycle one-hot pulse to the requesting load-queue entry.
// Ports:
//   clock, reset                         clock, asynchronous active-low reset
//   req_valid/req_addr/req_lq_idx        load request from the arbiter
//   req_ready                            request accepted when valid && ready
//   lq_clean                             squash pending and in-flight loads
//   proc2mem_command/proc2mem_addr       bus command (BUS_NONE/BUS_LOAD)
//   mem2proc_response                    accept tag (0 = rejected)
//   mem2proc_data/mem2proc_tag           data return (tag 0 = none)
//   lq_mem_data_out/lq_mem_data_valid    registered data and one-hot pulse
//   outstanding                          in-flight load count
//   err_unknown_tag                      sticky: return for an unowned tag
module lq_mem_responder
  import lq_mem_responder_pkg::*;
#(
  parameter  int LQ_SIZE  = 8,
  parameter  int MAX_OUT  = 4,
  localparam int LQ_IDX_W = $clog2(LQ_SIZE),
  localparam int CNT_W    = $clog2(MAX_OUT + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic [63:0]          req_addr,
  input  logic [LQ_IDX_W-1:0]  req_lq_idx,
  output logic                 req_ready,
  input  logic                 lq_clean,
  output logic [1:0]           proc2mem_command,
  output logic [63:0]          proc2mem_addr,
  input  logic [MEM_TAG_W-1:0] mem2proc_response,
  input  logic [63:0]          mem2proc_data,
  input  logic [MEM_TAG_W-1:0] mem2proc_tag,
  output logic [63:0]          lq_mem_data_out,
  output logic [LQ_SIZE-1:0]   lq_mem_data_valid,
  output logic [CNT_W-1:0]     outstanding,
  output logic                 err_unknown_tag
);

  lq_mem_state_e      state_q, state_d;
  lq_mem_pending_t    pend_q, pend_d;
  logic [63:0]        data_out_q, data_out_d;
  logic [LQ_SIZE-1:0] data_valid_q, data_valid_d;
  logic               err_q, err_d;

  logic               tt_wr_en;
  lq_mem_tag_entry_t  tt_wr_entry;
  lq_mem_tag_entry_t  tt_rd_entry;
  logic               room_idle;
  logic               room_after_issue;

  lq_mem_tag_table #(
    .CNT_W (CNT_W)
  ) u_tag_table (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (tt_wr_en),
    .wr_tag      (mem2proc_response),
    .wr_entry    (tt_wr_entry),
    .rd_tag      (mem2proc_tag),
    .rd_entry    (tt_rd_entry),
    .clear_live  (lq_clean),
    .outstanding (outstanding)
  );

  assign room_idle        = (int'(outstanding) < MAX_OUT);
  // Back-to-back acceptance only if the load being issued now still leaves room.
  assign room_after_issue = (int'(outstanding) + 1 < MAX_OUT);

  // NOTE: every combinational output gets a default before the case so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d          = state_q;
    pend_d           = pend_q;
    req_ready        = 1'b0;
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    tt_wr_en         = 1'b0;
    tt_wr_entry      = '0;

    unique case (state_q)
      S_IDLE: begin
        req_ready = room_idle && !lq_clean;
      end
      S_ISSUE: begin
        proc2mem_command = BUS_LOAD;
        proc2mem_addr    = pend_q.addr;
        // A zero response leaves everything as is: retry next cycle.
        if (mem2proc_response != '0) begin
          tt_wr_en    = 1'b1;
          tt_wr_entry = '{valid: 1'b1, live: !lq_clean, lq_idx: pend_q.lq_idx};
          req_ready   = room_after_issue && !lq_clean;
          state_d     = S_IDLE;
        end
      end
      default: ;
    endcase

    if (req_valid && req_ready) begin
      pend_d  = '{addr: req_addr, lq_idx: LQ_IDX_MAX_W'(req_lq_idx)};
      state_d = S_ISSUE;
    end

    if (lq_clean) begin
      state_d = S_IDLE;
      pend_d  = '0;
    end
  end

  // Return path: data and pulse are registered, so they appear the cycle
  // after the tag is presented.
  always_comb begin
    data_out_d   = data_out_q;
    data_valid_d = '0;
    err_d        = err_q;
    if (mem2proc_tag != '0) begin
      if (tt_rd_entry.valid) begin
        if (tt_rd_entry.live) begin
          data_out_d   = mem2proc_data;
          data_valid_d = LQ_SIZE'(1) << tt_rd_entry.lq_idx;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // NOTE: state is updated only with non-blocking assignments so all flops
  // sample the values computed in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pend_q       <= '0;
      data_out_q   <= '0;
      data_valid_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      err_q        <= err_d;
    end
  end

  assign lq_mem_data_out   = data_out_q;
  assign lq_mem_data_valid = data_valid_q;
  assign err_unknown_tag   = err_q;

endmodule

// File: tb/tb_lq_mem_responder.sv
// Self-checking bench for lq_mem_responder: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// transaction-level model (set of owned tags, one pending request slot).
module tb_lq_mem_responder;

  localparam int LQ_SIZE = 8;
  localparam int MAX_OUT = 4;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic [63:0] req_addr;
  logic [2:0]  req_lq_idx;
  logic        req_ready;
  logic        lq_clean;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;
  logic [63:0] lq_mem_data_out;
  logic [7:0]  lq_mem_data_valid;
  logic [2:0]  outstanding;
  logic        err_unknown_tag;

  lq_mem_responder #(
    .LQ_SIZE (LQ_SIZE),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_addr          (req_addr),
    .req_lq_idx        (req_lq_idx),
    .req_ready         (req_ready),
    .lq_clean          (lq_clean),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .mem2proc_response (mem2proc_response),
    .mem2proc_data     (mem2proc_data),
    .mem2proc_tag      (mem2proc_tag),
    .lq_mem_data_out   (lq_mem_data_out),
    .lq_mem_data_valid (lq_mem_data_valid),
    .outstanding       (outstanding),
    .err_unknown_tag   (err_unknown_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  // ---------------- behavioural model ----------------
  bit          m_pend;
  logic [63:0] m_paddr;
  int          m_pidx;
  bit          m_valid [16];
  bit          m_live  [16];
  int          m_idx   [16];
  int          m_out;
  logic [7:0]  m_pulse;
  logic [63:0] m_data;
  bit          m_err;

  function automatic void model_reset();
    m_pend  = 0;
    m_paddr = '0;
    m_pidx  = 0;
    for (int t = 0; t < 16; t++) begin
      m_valid[t] = 0;
      m_live[t]  = 0;
      m_idx[t]   = 0;
    end
    m_out   = 0;
    m_pulse = '0;
    m_data  = '0;
    m_err   = 0;
  endfunction

  // Whether the responder may take a request this cycle, given the inputs.
  function automatic bit model_ready();
    if (lq_clean) return 0;
    if (!m_pend) return (m_out < MAX_OUT);
    return (mem2proc_response != 0) && (m_out + 1 < MAX_OUT);
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  function automatic void model_step();
    bit rdy;
    int rt;
    int wt;
    rdy = model_ready();
    rt  = int'(mem2proc_tag);
    wt  = int'(mem2proc_response);
    m_pulse = '0;
    if (rt != 0) begin
      if (m_valid[rt]) begin
        if (m_live[rt]) begin
          m_pulse = 8'(1) << m_idx[rt];
          m_data  = mem2proc_data;
        end
        m_valid[rt] = 0;
        m_live[rt]  = 0;
        m_out--;
      end else begin
        m_err = 1;
      end
    end
    if (lq_clean) begin
      for (int t = 0; t < 16; t++) m_live[t] = 0;
    end
    if (m_pend && wt != 0) begin
      m_valid[wt] = 1;
      m_live[wt]  = !lq_clean;
      m_idx[wt]   = m_pidx;
      m_out++;
      m_pend = 0;
    end
    if (req_valid && rdy) begin
      m_pend  = 1;
      m_paddr = req_addr;
      m_pidx  = int'(req_lq_idx);
    end
    if (lq_clean) m_pend = 0;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_regs();
    check("outstanding", 64'(outstanding), 64'(m_out));
    check("command", 64'(proc2mem_command), m_pend ? 64'd1 : 64'd0);
    check("addr", proc2mem_addr, m_pend ? m_paddr : 64'd0);
    check("data_valid", 64'(lq_mem_data_valid), 64'(m_pulse));
    check("data_out", lq_mem_data_out, m_data);
    check("err_unknown_tag", 64'(err_unknown_tag), 64'(m_err));
  endtask

  // One clock: drive inputs after the falling edge, check the combinational
  // ready, step the model, then check the registered outputs at the next
  // falling edge.
  task automatic cycle(input bit rv, input logic [63:0] a, input int ix, input bit cl,
                       input int rsp, input int rt, input logic [63:0] rd);
    req_valid         = rv;
    req_addr          = a;
    req_lq_idx        = 3'(ix);
    lq_clean          = cl;
    mem2proc_response = 4'(rsp);
    mem2proc_tag      = 4'(rt);
    mem2proc_data     = rd;
    #1;
    check("req_ready", 64'(req_ready), 64'(model_ready()));
    model_step();
    @(negedge clock);
    check_regs();
  endtask

  task automatic idle();
    cycle(0, '0, 0, 0, 0, 0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    req_valid = 0; req_addr = '0; req_lq_idx = '0; lq_clean = 0;
    mem2proc_response = '0; mem2proc_data = '0; mem2proc_tag = '0;
    model_reset();
    repeat (2) @(negedge clock);
    check_regs();
    check("reset_cmd", 64'(proc2mem_command), 64'd0);
    reset = 1'b1;
    #1;
    check("ready_after_reset", 64'(req_ready), 64'd1);

    // Single load: idx 3, addr 0x100, tag 5, return three cycles later.
    cycle(1, 64'h100, 3, 0, 0, 0, '0);
    check("t1_cmd", 64'(proc2mem_command), 64'd1);
    check("t1_addr", proc2mem_addr, 64'h100);
    cycle(0, '0, 0, 0, 5, 0, '0);
    check("t1_out1", 64'(outstanding), 64'd1);
    idle();
    idle();
    cycle(0, '0, 0, 0, 0, 5, 64'hDEAD);
    check("t1_pulse", 64'(lq_mem_data_valid), 64'h08);
    check("t1_data", lq_mem_data_out, 64'hDEAD);
    check("t1_out0", 64'(outstanding), 64'd0);
    idle();
    check("t1_pulse_gone", 64'(lq_mem_data_valid), 64'h00);

    // Two rejections, then accept with tag 2.
    cycle(1, 64'h100, 1, 0, 0, 0, '0);
    check("t2_addr_c1", proc2mem_addr, 64'h100);
    cycle(1, 64'h200, 2, 0, 0, 0, '0);
    check("t2_addr_c2", proc2mem_addr, 64'h100);
    cycle(1, 64'h200, 2, 0, 0, 0, '0);
    check("t2_addr_c3", proc2mem_addr, 64'h100);
    check("t2_cmd_c3", 64'(proc2mem_command), 64'd1);
    cycle(0, '0, 0, 0, 2, 0, '0);
    check("t2_cmd_done", 64'(proc2mem_command), 64'd0);
    cycle(0, '0, 0, 0, 0, 2, 64'h22);
    check("t2_pulse", 64'(lq_mem_data_valid), 64'h02);

    // Four back-to-back loads, tags 1..4, fifth stalled; returns 3,1,4,2.
    cycle(1, 64'h1000, 0, 0, 0, 0, '0);
    cycle(1, 64'h1008, 1, 0, 1, 0, '0);
    cycle(1, 64'h1010, 2, 0, 2, 0, '0);
    cycle(1, 64'h1018, 3, 0, 3, 0, '0);
    cycle(1, 64'h1020, 4, 0, 4, 0, '0);
    check("t3_full", 64'(outstanding), 64'd4);
    check("t3_stall_cmd", 64'(proc2mem_command), 64'd0);
    cycle(1, 64'h1020, 4, 0, 0, 3, 64'h33);
    check("t3_pulse_tag3", 64'(lq_mem_data_valid), 64'h04);
    cycle(1, 64'h1020, 4, 0, 0, 1, 64'h11);
    check("t3_pulse_tag1", 64'(lq_mem_data_valid), 64'h01);
    check("t3_fifth_issued", 64'(proc2mem_command), 64'd1);
    cycle(0, '0, 0, 0, 5, 4, 64'h44);
    check("t3_pulse_tag4", 64'(lq_mem_data_valid), 64'h08);
    cycle(0, '0, 0, 0, 0, 2, 64'h222);
    check("t3_pulse_tag2", 64'(lq_mem_data_valid), 64'h02);
    cycle(0, '0, 0, 0, 0, 5, 64'h55);
    check("t3_pulse_tag5", 64'(lq_mem_data_valid), 64'h10);
    check("t3_drained", 64'(outstanding), 64'd0);

    // Same-cycle return of tag 1 and reassignment of tag 1 to idx 6.
    cycle(1, 64'h600, 5, 0, 0, 0, '0);
    cycle(0, '0, 0, 0, 1, 0, '0);
    cycle(1, 64'h700, 6, 0, 0, 0, '0);
    cycle(0, '0, 0, 0, 1, 1, 64'hA5);
    check("t6_old_pulse", 64'(lq_mem_data_valid), 64'h20);
    check("t6_out_same", 64'(outstanding), 64'd1);
    cycle(0, '0, 0, 0, 0, 1, 64'hB6);
    check("t6_new_pulse", 64'(lq_mem_data_valid), 64'h40);
    check("t6_new_data", lq_mem_data_out, 64'hB6);

    // Clean with tags 1,2 in flight and a pending retry.
    cycle(1, 64'h800, 0, 0, 0, 0, '0);
    cycle(1, 64'h808, 1, 0, 1, 0, '0);
    cycle(1, 64'h810, 2, 0, 2, 0, '0);
    cycle(0, '0, 0, 0, 0, 0, '0);
    cycle(0, '0, 0, 1, 0, 0, '0);
    check("t4_no_load", 64'(proc2mem_command), 64'd0);
    check("t4_out2", 64'(outstanding), 64'd2);
    cycle(0, '0, 0, 0, 0, 1, 64'h1);
    check("t4_no_pulse1", 64'(lq_mem_data_valid), 64'h00);
    cycle(0, '0, 0, 0, 0, 2, 64'h2);
    check("t4_no_pulse2", 64'(lq_mem_data_valid), 64'h00);
    check("t4_out0", 64'(outstanding), 64'd0);

    // Return for an unowned tag.
    cycle(0, '0, 0, 0, 0, 7, 64'h7);
    check("t5_err", 64'(err_unknown_tag), 64'd1);
    check("t5_out", 64'(outstanding), 64'd0);
    idle();
    check("t5_err_sticky", 64'(err_unknown_tag), 64'd1);

    // Reset mid-operation: tag 9 in flight and a pending request.
    cycle(1, 64'h900, 2, 0, 0, 0, '0);
    cycle(0, '0, 0, 0, 9, 0, '0);
    cycle(1, 64'h980, 3, 0, 0, 0, '0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_regs();
    @(negedge clock);
    reset = 1'b1;
    cycle(0, '0, 0, 0, 0, 9, 64'h9);
    check("rst_stale_err", 64'(err_unknown_tag), 64'd1);
    check("rst_stale_out", 64'(outstanding), 64'd0);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      int rt;
      int rsp;
      int vt[$];
      rt  = 0;
      rsp = 0;
      for (int t = 1; t < 16; t++) if (m_valid[t]) vt.push_back(t);
      if (vt.size() > 0 && $urandom_range(2) == 0) rt = vt[$urandom_range(vt.size() - 1)];
      if (m_pend && $urandom_range(3) != 0) begin
        for (int k = 0; k < 20; k++) begin
          int t;
          t = int'($urandom_range(15, 1));
          if (!m_valid[t] || t == rt) begin
            rsp = t;
            break;
          end
        end
      end
      cycle(bit'($urandom_range(1)), {$urandom, $urandom}, int'($urandom_range(7)),
            ($urandom_range(31) == 0), rsp, rt, {$urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/lq_mem_responder.md
# lq_mem_responder

Memory-side responder for the load queue. It accepts one load request per cycle from the load-queue request arbiter and issues it on the processor–memory bus. It tracks outstanding requests by memory tag and returns each load's data as a one-cycle, one-hot data-valid pulse to the load-queue entry that asked for it. It sits between the load queue (data-in / data-valid inputs of each entry) and the shared data-memory port.

## Interface
- `LQ_SIZE`, 8, load-queue entries; `LQ_IDX_W = $clog2(LQ_SIZE)`
- `MAX_OUT`, 4, maximum in-flight loads (1..15)
- `clock`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low
- `req_valid`  in  1  load request present
- `req_addr`  in  64  load address
- `req_lq_idx`  in  LQ_IDX_W  requesting entry
- `req_ready`  out  1  request accepted this cycle when `req_valid && req_ready`
- `lq_clean`  in  1  squash: drop pending and in-flight loads
- `proc2mem_command`  out  2  `BUS_NONE=0`, `BUS_LOAD=1`
- `proc2mem_addr`  out  64  address of issued load
- `mem2proc_response`  in  4  nonzero = command accepted with this tag; 0 = rejected
- `mem2proc_data`  in  64  returned data
- `mem2proc_tag`  in  4  nonzero = data for this tag valid this cycle
- `lq_mem_data_out`  out  64  data to the load queue
- `lq_mem_data_valid`  out  LQ_SIZE  one-hot; bit i = entry i takes `lq_mem_data_out`
- `outstanding`  out  3  in-flight count
- `err_unknown_tag`  out  1  sticky: a return arrived for an unowned tag

## Operation
- Two-state FSM, plus a pending register {addr, lq_idx}.
- IDLE
  - `req_ready = (outstanding < MAX_OUT)`.
  - On accept: latch the pending register, go to ISSUE.
- ISSUE
  - Drive `BUS_LOAD` and the pending address.
  - Response 0: stay in ISSUE and retry next cycle with identical address.
  - Response T≠0: write `tag_tbl[T] = {valid=1, live=1, lq_idx}` and increment `outstanding`.
    - If `req_valid` and the incremented count < MAX_OUT: `req_ready=1`, latch the new request, stay in ISSUE (back-to-back).
    - Otherwise go to IDLE.
  - `req_ready` is 0 in ISSUE unless the response is nonzero.
- In IDLE, `proc2mem_command = BUS_NONE` and `proc2mem_addr = 0`.
- Return path, when `mem2proc_tag = T ≠ 0`:
  - If `tag_tbl[T].valid`: clear the entry and decrement `outstanding`.
  - If additionally `.live`: register `mem2proc_data` and set the bit `tag_tbl[T].lq_idx` in `lq_mem_data_valid`.
  - If not valid: set `err_unknown_tag` and change nothing else.
- `lq_clean`:
  - Returns FSM to IDLE and discards the pending request.
  - Clears `.live` on every valid entry; squashed loads still retire their tags on return, but produce no pulse.
  - `req_ready` is 0 during a clean cycle.
  - An accept (nonzero response) in the same cycle is recorded with `live=0`.
- Simultaneous return of tag T and acceptance reassigning tag T: clear first, then set; the new entry wins. `outstanding` is unchanged (+1−1).
- `outstanding` never exceeds MAX_OUT and never underflows. A return for an invalid tag does not decrement.

## Timing
- Accept at cycle N → `BUS_LOAD` at N+1 at the earliest.
- Return at cycle M → `lq_mem_data_valid` pulse for exactly one cycle at M+1, with registered data.
- Back-to-back issue sustains one load per cycle while memory accepts.
- Reset values:
  - FSM IDLE; pending register, `tag_tbl`, `outstanding` = 0.
  - `proc2mem_command = BUS_NONE`, `proc2mem_addr = 0`.
  - `lq_mem_data_out = 0`, `lq_mem_data_valid = 0`, `err_unknown_tag = 0`.
  - `req_ready` = 1 the first cycle after reset is released.
- Reset asserted mid-operation:
  - All state clears immediately; in-flight loads are forgotten.
  - Later returns for those tags set `err_unknown_tag`.

## Structure
- Shared package additions:
  - `BUS_NONE`, `BUS_LOAD` command encodings
  - `MEM_TAG_W = 4`
  - `lq_mem_tag_entry_t` = {valid, live, lq_idx}
- One sub-module is natural: `lq_mem_tag_table`, 15 entries indexed by tag 1..15. It has one write port (issue), one read-and-clear port (return), a broadcast live-clear, and owns the `outstanding` counter.

## Test plan
- Single load, idx 3, addr `0x100`; memory accepts with tag 5, returns tag 5 with data `0xDEAD` three cycles later → `lq_mem_data_valid = 8'b0000_1000`, data `0xDEAD` one cycle after the return; `outstanding` goes 1 → 0.
- Memory rejects twice, then accepts with tag 2 → `BUS_LOAD` with `0x100` held for 3 cycles, `req_ready` low until the accept.
- Four back-to-back requests from idx 0..3 with tags 1..4, returns in order 3,1,4,2 → pulses to idx 2,0,3,1; a 5th request is stalled (`req_ready = 0`) until the first return.
- `lq_clean` with tags 1,2 in flight and a pending retry → no `BUS_LOAD` next cycle; returns of tags 1,2 produce no pulse and `outstanding` goes to 0.
- Return of tag 7 with no entry → `err_unknown_tag = 1` and stays high; `outstanding` is unchanged.
- Same-cycle return of tag 1 and accept reassigning tag 1 to idx 6 → pulse for the old idx; the later return of tag 1 pulses idx 6.
